mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
Memory-access stage feeding mem_wb. It takes the instruction held in ex_mem and either passes ALU results straight through or runs a load/store on the data bus. It holds the pipeline with stallreq_o until the bus acknowledges, then presents a write-back triple (address, enable, data) for mem_wb to capture. Big-endian byte lanes; stall vector semantics are Stop=1.

Parameters:
AW, 32, data-bus address width
DW, 32, data width; fixed 32 (byte-lane logic assumes 4 lanes)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
stall  in  6  pipeline stall vector from ctrl; bit 4 = mem_wb hold
waddr_i  in  5  destination register from ex_mem
we_i  in  1  register write enable from ex_mem
wdata_i  in  32  ALU result (non-memory ops)
mem_op_i  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; others treated as NONE
mem_addr_i  in  32  effective address
store_data_i  in  32  store source register value
waddr_o  out  5  to mem_wb
we_o  out  1  to mem_wb
wdata_o  out  32  to mem_wb
stallreq_o  out  1  stall request to ctrl
misalign_o  out  1  one-cycle flag: misaligned access suppressed
bus_req_o  out  1  data-bus request
bus_we_o  out  1  1 = store
bus_addr_o  out  AW  word-aligned address ({addr[31:2],2'b00})
bus_sel_o  out  4  byte enables, bit 3 = bits 31:24
bus_wdata_o  out  32  lane-replicated store data
bus_ack_i  in  1  one-cycle completion
bus_rdata_i  in  32  read data, valid with ack

Behaviour:
- Reset (rst=0, async): state IDLE; bus_req_o, bus_we_o, misalign_o, stallreq_o = 0; bus_addr_o, bus_sel_o, bus_wdata_o, result register = 0.
- States: IDLE, WAIT_ACK, DONE.
- IDLE + NONE/invalid op: waddr_o/we_o/wdata_o = inputs, combinational; stallreq_o=0.
- IDLE + aligned memory op: stallreq_o=1 combinationally this cycle. Register bus_req_o=1 with addr/sel/we/wdata, then go to WAIT_ACK.
- Alignment rule: halfword needs addr[0]=0. Word needs addr[1:0]=00. Byte is always aligned.
- IDLE + misaligned op: no bus request, stallreq_o=0, we_o=0, misalign_o=1 for one cycle, stay IDLE.
- WAIT_ACK: stallreq_o=1; bus_req_o and all bus outputs held stable until bus_ack_i.
- On ack: drop bus_req_o next edge, capture formatted result, go to DONE. Ack in the same cycle req rises is legal; ack while req=0 is ignored.
- DONE: stallreq_o=0. Outputs are waddr_i and result: we_o=we_i for loads, 0 for stores. Go to IDLE on stall[4]=0 (mem_wb captured); otherwise hold DONE.
- Byte select (big-endian):
  - Byte: addr[1:0]=00→1000, 01→0100, 10→0010, 11→0001.
  - Half: addr[1]=0→1100, 1→0011.
  - Word: 1111.
- Store data: SB {4{sd[7:0]}}, SH {2{sd[15:0]}}, SW sd.
- Load format: selected lane right-justified; LB/LH sign-extend, LBU/LHU zero-extend.
- Reset mid-transaction: bus_req_o drops immediately and the access is abandoned; the bus is required to tolerate this.
- Latency: minimum 3 cycles from memory op in IDLE to DONE (issue, ack, DONE) with zero-wait ack.

Decomposition:
- Shared defines file holds mem_op encodings, state encodings, and the existing Stop/NoStop and RstEnable-style constants. Add an active-low reset constant.
- One combinational sub-module, lsu_align, computes bus_sel, replicated store data, load extraction and the misalign flag.
- The FSM stays in mem_lsu.

Test Plan:
- Passthrough: mem_op=0, waddr=5, we=1, wdata=0x1234 → same values on outputs the same cycle; stallreq_o=0, bus_req_o=0.
- LB sign-extension: addr=0x1001, rdata=0x11F02233, ack 2 cycles after req.
  - bus_sel_o=0100, bus_addr_o=0x1000.
  - In DONE, wdata_o=0xFFFFFFF0 and we_o=1.
  - stallreq_o high exactly until DONE.
- SH at addr=0x2002, store_data=0xAABBCCDD → bus_we_o=1, bus_sel_o=0011, bus_wdata_o=0xCCDDCCDD; in DONE, we_o=0.
- LW misaligned at addr=0x3001 → misalign_o=1 for one cycle, no bus_req_o, we_o=0, stallreq_o=0.
- Downstream hold: in DONE hold stall[4]=1 for 3 cycles → stays DONE with stable outputs; returns to IDLE on the edge after stall[4]=0.
- Reset mid-operation: rst=0 during WAIT_ACK → bus_req_o=0 and state IDLE immediately (no clock edge needed); a later stray ack is ignored.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the memory-access stage: mem_op codes, LSU states,
// stall/reset polarity constants and small op-classification helpers.
package mem_lsu_pkg;

   // Memory operation codes carried in ex_mem; unlisted codes behave as NONE
   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_LB   = 4'd1,
      OP_LBU  = 4'd2,
      OP_LH   = 4'd3,
      OP_LHU  = 4'd4,
      OP_LW   = 4'd5,
      OP_SB   = 4'd6,
      OP_SH   = 4'd7,
      OP_SW   = 4'd8
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_ACK = 2'd1,
      ST_DONE     = 2'd2
   } lsu_state_e;

   // Stall vector polarity and the bit that holds mem_wb
   localparam logic STOP         = 1'b1;
   localparam logic NO_STOP      = 1'b0;
   localparam int   STALL_MEM_WB = 4;

   // Reset levels: legacy active-high pair plus the active-low level used here
   localparam logic RST_ENABLE   = 1'b1;
   localparam logic RST_DISABLE  = 1'b0;
   localparam logic RST_N_ENABLE = 1'b0;

   function automatic logic is_load(input logic [3:0] op);
      return (op >= OP_LB) && (op <= OP_LW);
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return (op >= OP_SB) && (op <= OP_SW);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: big-endian byte enables, lane-replicated
// store data, load extraction with sign/zero extension, misalign detect.
module lsu_align
   import mem_lsu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  sel,
   output logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic        misalign
);

   mem_op_e     op_e;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign op_e = mem_op_e'(op);

   // Pick the addressed lanes out of the read word (lane 0 = bits 31:24)
   always_comb begin
      byte_v = rdata[31:24];
      case (addr_lo)
         2'd0: byte_v = rdata[31:24];
         2'd1: byte_v = rdata[23:16];
         2'd2: byte_v = rdata[15:8];
         2'd3: byte_v = rdata[7:0];
         default: byte_v = rdata[31:24];
      endcase
      half_v = addr_lo[1] ? rdata[15:0] : rdata[31:16];
   end

   // Byte enables, store replication, load format and alignment per access size
   always_comb begin
      sel       = 4'b0000;
      wdata     = store_data;
      load_data = 32'h0;
      misalign  = 1'b0;
      case (op_e)
         OP_LB, OP_LBU, OP_SB: begin
            sel = 4'b1000 >> addr_lo;
         end
         OP_LH, OP_LHU, OP_SH: begin
            sel      = addr_lo[1] ? 4'b0011 : 4'b1100;
            misalign = addr_lo[0];
         end
         OP_LW, OP_SW: begin
            sel      = 4'b1111;
            misalign = |addr_lo;
         end
         default: sel = 4'b0000;
      endcase
      case (op_e)
         OP_SB:   wdata = {4{store_data[7:0]}};
         OP_SH:   wdata = {2{store_data[15:0]}};
         default: wdata = store_data;
      endcase
      case (op_e)
         OP_LB:   load_data = {{24{byte_v[7]}}, byte_v};
         OP_LBU:  load_data = {24'h0, byte_v};
         OP_LH:   load_data = {{16{half_v[15]}}, half_v};
         OP_LHU:  load_data = {16'h0, half_v};
         OP_LW:   load_data = rdata;
         default: load_data = 32'h0;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage: passes ALU results through, or runs one load/store on
// the data bus while holding the pipeline, then presents the write-back triple.
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [5:0]    stall,
   input  logic [4:0]    waddr_i,
   input  logic          we_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [3:0]    mem_op_i,
   input  logic [31:0]   mem_addr_i,
   input  logic [DW-1:0] store_data_i,
   output logic [4:0]    waddr_o,
   output logic          we_o,
   output logic [DW-1:0] wdata_o,
   output logic          stallreq_o,
   output logic          misalign_o,
   output logic          bus_req_o,
   output logic          bus_we_o,
   output logic [AW-1:0] bus_addr_o,
   output logic [3:0]    bus_sel_o,
   output logic [DW-1:0] bus_wdata_o,
   input  logic          bus_ack_i,
   input  logic [DW-1:0] bus_rdata_i
);

   lsu_state_e  state_q, state_d;
   logic [3:0]  op_q;
   logic [1:0]  addr_lo_q;
   logic [31:0] result_q;

   logic [3:0]  al_op;
   logic [1:0]  al_addr;
   logic [3:0]  al_sel;
   logic [31:0] al_wdata;
   logic [31:0] al_load;
   logic        al_misalign;
   logic        is_mem;
   logic        rst_off;
   logic        unused_stall;

   assign unused_stall = ^{stall[5], stall[3:0]};
   assign rst_off      = (rst != RST_N_ENABLE);
   assign is_mem       = is_load(mem_op_i) | is_store(mem_op_i);

   // In IDLE the aligner sees the incoming op; afterwards the latched op, so
   // the load is formatted against the access that was actually issued.
   assign al_op   = (state_q == ST_IDLE) ? mem_op_i : op_q;
   assign al_addr = (state_q == ST_IDLE) ? mem_addr_i[1:0] : addr_lo_q;

   lsu_align u_align (
      .op         (al_op),
      .addr_lo    (al_addr),
      .store_data (store_data_i),
      .rdata      (bus_rdata_i),
      .sel        (al_sel),
      .wdata      (al_wdata),
      .load_data  (al_load),
      .misalign   (al_misalign)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_N_ENABLE) state_q <= ST_IDLE;
      else                     state_q <= state_d;
   end

   // Next state, stall request, misalign pulse and write-back triple
   always_comb begin
      state_d    = state_q;
      stallreq_o = 1'b0;
      misalign_o = 1'b0;
      waddr_o    = waddr_i;
      we_o       = we_i;
      wdata_o    = wdata_i;
      case (state_q)
         ST_IDLE: begin
            if (is_mem) begin
               we_o = 1'b0;
               if (al_misalign) begin
                  misalign_o = rst_off;
               end else begin
                  stallreq_o = rst_off;
                  state_d    = ST_WAIT_ACK;
               end
            end
         end
         ST_WAIT_ACK: begin
            stallreq_o = 1'b1;
            we_o       = 1'b0;
            if (bus_ack_i && bus_req_o) state_d = ST_DONE;
         end
         ST_DONE: begin
            wdata_o = result_q;
            we_o    = is_load(op_q) ? we_i : 1'b0;
            if (stall[STALL_MEM_WB] == NO_STOP) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus request registers and captured load result
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_N_ENABLE) begin
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_sel_o   <= 4'b0000;
         bus_wdata_o <= '0;
         op_q        <= 4'd0;
         addr_lo_q   <= 2'd0;
         result_q    <= 32'h0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (state_d == ST_WAIT_ACK) begin
                  bus_req_o   <= 1'b1;
                  bus_we_o    <= is_store(mem_op_i);
                  bus_addr_o  <= {mem_addr_i[AW-1:2], 2'b00};
                  bus_sel_o   <= al_sel;
                  bus_wdata_o <= al_wdata;
                  op_q        <= mem_op_i;
                  addr_lo_q   <= mem_addr_i[1:0];
               end
            end
            ST_WAIT_ACK: begin
               if (bus_ack_i) begin
                  bus_req_o <= 1'b0;
                  bus_we_o  <= 1'b0;
                  result_q  <= al_load;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed vector table, randomized transactions against a
// size/offset arithmetic model, and hand sequences for reset and hold cases.
module tb_mem_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic [4:0]  waddr_i;
   logic        we_i;
   logic [31:0] wdata_i;
   logic [3:0]  mem_op_i;
   logic [31:0] mem_addr_i;
   logic [31:0] store_data_i;
   logic [4:0]  waddr_o;
   logic        we_o;
   logic [31:0] wdata_o;
   logic        stallreq_o;
   logic        misalign_o;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_wdata_o;
   logic        bus_ack_i;
   logic [31:0] bus_rdata_i;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_lsu #(.AW(32), .DW(32)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .waddr_i(waddr_i), .we_i(we_i), .wdata_i(wdata_i),
      .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .store_data_i(store_data_i),
      .waddr_o(waddr_o), .we_o(we_o), .wdata_o(wdata_o),
      .stallreq_o(stallreq_o), .misalign_o(misalign_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
      .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
      .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
   );

   // kind: 0 passthrough, 1 misaligned, 2 load, 3 store
   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr, sd, rd, alu;
      logic [4:0]  wa;
      logic        we;
      int          dly, hold, kind;
      logic [3:0]  e_sel;
      logic [31:0] e_bwd, e_res;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, sd, rd, alu,
                               input logic [4:0] wa, input logic we, input int dly, hold, kind,
                               input logic [3:0] e_sel, input logic [31:0] e_bwd, e_res);
      vec_t v;
      v.op = op; v.addr = addr; v.sd = sd; v.rd = rd; v.alu = alu; v.wa = wa; v.we = we;
      v.dly = dly; v.hold = hold; v.kind = kind; v.e_sel = e_sel; v.e_bwd = e_bwd; v.e_res = e_res;
      return v;
   endfunction

   // Reference model: access size and byte offset arithmetic on a big-endian word
   function automatic vec_t model(input vec_t v);
      vec_t   r = v;
      int     size, off;
      bit     ld, st, sgn;
      longint raw, mask;
      ld   = (v.op >= 1 && v.op <= 5);
      st   = (v.op >= 6 && v.op <= 8);
      sgn  = (v.op == 1 || v.op == 3);
      size = (v.op == 1 || v.op == 2 || v.op == 6) ? 1 :
             (v.op == 3 || v.op == 4 || v.op == 7) ? 2 : 4;
      off  = int'(v.addr % 4);
      if (!(ld || st))              r.kind = 0;
      else if (v.addr % size != 0)  r.kind = 1;
      else                          r.kind = ld ? 2 : 3;
      r.e_sel = 4'(((1 << size) - 1) << (4 - off - size));
      mask    = (64'd1 << (8 * size)) - 1;
      r.e_bwd = 32'h0;
      for (int k = 0; k < 4 / size; k++)
         r.e_bwd = r.e_bwd | 32'((longint'(v.sd) & mask) << (8 * size * k));
      raw = (longint'(v.rd) >> (8 * (4 - off - size))) & mask;
      if (sgn && raw > (mask >> 1)) raw = raw - (mask + 1);
      r.e_res = raw[31:0];
      return r;
   endfunction

   // Apply one instruction from IDLE and follow it back to IDLE
   task automatic run_txn(input vec_t v);
      logic [31:0] exp_addr;
      exp_addr = {v.addr[31:2], 2'b00};
      mem_op_i = v.op; mem_addr_i = v.addr; store_data_i = v.sd;
      wdata_i = v.alu; waddr_i = v.wa; we_i = v.we;
      stall = 6'b0; bus_ack_i = 1'b0;
      #1;
      if (v.kind == 0) begin
         chk("pass_waddr", 32'(waddr_o), 32'(v.wa));
         chk("pass_we", 32'(we_o), 32'(v.we));
         chk("pass_wdata", wdata_o, v.alu);
         chk("pass_stallreq", 32'(stallreq_o), 0);
         chk("pass_bus_req", 32'(bus_req_o), 0);
         @(posedge clk); #1;
      end else if (v.kind == 1) begin
         chk("mis_flag", 32'(misalign_o), 1);
         chk("mis_stallreq", 32'(stallreq_o), 0);
         chk("mis_we", 32'(we_o), 0);
         @(posedge clk); #1;
         mem_op_i = 4'd0;
         #1;
         chk("mis_no_req", 32'(bus_req_o), 0);
         chk("mis_flag_clear", 32'(misalign_o), 0);
      end else begin
         chk("issue_stallreq", 32'(stallreq_o), 1);
         @(posedge clk); #1;
         chk("wait_req", 32'(bus_req_o), 1);
         chk("wait_addr", bus_addr_o, exp_addr);
         chk("wait_sel", 32'(bus_sel_o), 32'(v.e_sel));
         chk("wait_we", 32'(bus_we_o), (v.kind == 3) ? 1 : 0);
         if (v.kind == 3) chk("wait_bwdata", bus_wdata_o, v.e_bwd);
         chk("wait_stallreq", 32'(stallreq_o), 1);
         for (int i = 0; i < v.dly; i++) begin
            @(posedge clk); #1;
            chk("hold_req", 32'(bus_req_o), 1);
            chk("hold_addr", bus_addr_o, exp_addr);
            chk("hold_sel", 32'(bus_sel_o), 32'(v.e_sel));
            chk("hold_stallreq", 32'(stallreq_o), 1);
         end
         bus_ack_i = 1'b1; bus_rdata_i = v.rd;
         #1;
         chk("ack_stallreq", 32'(stallreq_o), 1);
         @(posedge clk); #1;
         bus_ack_i = 1'b0; bus_rdata_i = $urandom;
         for (int h = 0; h <= v.hold; h++) begin
            stall = (h < v.hold) ? 6'b010000 : 6'b000000;
            #1;
            chk("done_stallreq", 32'(stallreq_o), 0);
            chk("done_req", 32'(bus_req_o), 0);
            chk("done_waddr", 32'(waddr_o), 32'(v.wa));
            chk("done_we", 32'(we_o), (v.kind == 2) ? 32'(v.we) : 0);
            if (v.kind == 2) chk("done_wdata", wdata_o, v.e_res);
            @(posedge clk); #1;
         end
         // Back in IDLE: the next instruction passes straight through
         mem_op_i = 4'd0; wdata_i = ~v.alu; we_i = 1'b1;
         #1;
         chk("back_idle_wdata", wdata_o, ~v.alu);
         chk("back_idle_stallreq", 32'(stallreq_o), 0);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[$];
      vec_t v;

      rst = 1'b0; stall = 6'b0; waddr_i = 5'd0; we_i = 1'b0; wdata_i = 32'h0;
      mem_op_i = 4'd0; mem_addr_i = 32'h0; store_data_i = 32'h0;
      bus_ack_i = 1'b0; bus_rdata_i = 32'h0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_bus_req", 32'(bus_req_o), 0);
      chk("rst_bus_we", 32'(bus_we_o), 0);
      chk("rst_bus_addr", bus_addr_o, 0);
      chk("rst_bus_sel", 32'(bus_sel_o), 0);
      chk("rst_bus_wdata", bus_wdata_o, 0);
      chk("rst_misalign", 32'(misalign_o), 0);
      chk("rst_stallreq", 32'(stallreq_o), 0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Directed vectors with hand-computed expectations
      tbl.push_back(mk(4'd0, 32'h0,    32'h0,        32'h0,        32'h1234, 5'd5, 1'b1, 0, 0, 0, 4'b0000, 32'h0,        32'h0));
      tbl.push_back(mk(4'd1, 32'h1001, 32'h0,        32'h11F02233, 32'h0,    5'd7, 1'b1, 2, 0, 2, 4'b0100, 32'h0,        32'hFFFFFFF0));
      tbl.push_back(mk(4'd7, 32'h2002, 32'hAABBCCDD, 32'h0,        32'h0,    5'd3, 1'b1, 1, 0, 3, 4'b0011, 32'hCCDDCCDD, 32'h0));
      tbl.push_back(mk(4'd5, 32'h3001, 32'h0,        32'h0,        32'h55,   5'd4, 1'b1, 0, 0, 1, 4'b0000, 32'h0,        32'h0));
      tbl.push_back(mk(4'd5, 32'h1004, 32'h0,        32'hDEADBEEF, 32'h0,    5'd9, 1'b1, 0, 3, 2, 4'b1111, 32'h0,        32'hDEADBEEF));
      tbl.push_back(mk(4'd2, 32'h1003, 32'h0,        32'h11F022A5, 32'h0,    5'd1, 1'b1, 0, 0, 2, 4'b0001, 32'h0,        32'h000000A5));
      tbl.push_back(mk(4'd3, 32'h1000, 32'h0,        32'h80017FFF, 32'h0,    5'd2, 1'b1, 1, 0, 2, 4'b1100, 32'h0,        32'hFFFF8001));
      tbl.push_back(mk(4'd4, 32'h1002, 32'h0,        32'h80017FFF, 32'h0,    5'd6, 1'b0, 0, 1, 2, 4'b0011, 32'h0,        32'h00007FFF));
      tbl.push_back(mk(4'd6, 32'h4001, 32'h12345678, 32'h0,        32'h0,    5'd8, 1'b1, 0, 0, 3, 4'b0100, 32'h78787878, 32'h0));
      tbl.push_back(mk(4'd8, 32'h4000, 32'hCAFEF00D, 32'h0,        32'h0,    5'd8, 1'b1, 0, 0, 3, 4'b1111, 32'hCAFEF00D, 32'h0));
      tbl.push_back(mk(4'd3, 32'h5003, 32'h0,        32'h0,        32'h0,    5'd1, 1'b1, 0, 0, 1, 4'b0000, 32'h0,        32'h0));
      tbl.push_back(mk(4'd7, 32'h5001, 32'h0,        32'h0,        32'h0,    5'd1, 1'b1, 0, 0, 1, 4'b0000, 32'h0,        32'h0));
      tbl.push_back(mk(4'd9, 32'h6000, 32'h0,        32'h0,        32'hBEEF, 5'd11, 1'b1, 0, 0, 0, 4'b0000, 32'h0,       32'h0));
      tbl.push_back(mk(4'd15, 32'h6001, 32'h0,       32'h0,        32'h77,   5'd12, 1'b0, 0, 0, 0, 4'b0000, 32'h0,       32'h0));
      foreach (tbl[i]) run_txn(tbl[i]);

      // Randomized transactions checked against the arithmetic model
      for (int i = 0; i < 60; i++) begin
         v.op   = 4'($urandom_range(0, 10));
         v.addr = $urandom;
         v.sd   = $urandom;
         v.rd   = $urandom;
         v.alu  = $urandom;
         v.wa   = 5'($urandom);
         v.we   = 1'($urandom);
         v.dly  = $urandom_range(0, 3);
         v.hold = $urandom_range(0, 2);
         run_txn(model(v));
      end

      // Reset while waiting for ack: request drops at once, stray ack ignored
      mem_op_i = 4'd5; mem_addr_i = 32'h7000; we_i = 1'b1; waddr_i = 5'd3;
      @(posedge clk); #1;
      chk("rmid_req_before", 32'(bus_req_o), 1);
      rst = 1'b0;
      #1;
      chk("rmid_req_dropped", 32'(bus_req_o), 0);
      chk("rmid_sel_cleared", 32'(bus_sel_o), 0);
      mem_op_i = 4'd0; wdata_i = 32'h0BAD_F00D;
      #1;
      chk("rmid_stallreq", 32'(stallreq_o), 0);
      rst = 1'b1;
      bus_ack_i = 1'b1; bus_rdata_i = 32'h12345678;
      @(posedge clk); #1;
      bus_ack_i = 1'b0;
      #1;
      chk("rmid_stray_ack_req", 32'(bus_req_o), 0);
      chk("rmid_stray_ack_wdata", wdata_o, 32'h0BAD_F00D);
      chk("rmid_stray_ack_stall", 32'(stallreq_o), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
